// File: rtl/screen_compositor.sv
// screen_compositor: pixel_index -> x/y for the renderers, then selects/mixes
// the renderer outputs into the RGB565 pixel, and sequences the
// game -> wipe -> flashing victory transition.
module screen_compositor #(
  parameter int unsigned WIPE_STEP    = 2,
  parameter int unsigned FLASH_PERIOD = 8,
  parameter int unsigned FLASH_COUNT  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] pixel_index,
  input  logic        frame_begin,
  input  logic        game_won,
  input  logic        restart,
  output logic [6:0]  x,
  output logic [5:0]  y,
  input  logic [15:0] game_data,
  input  logic [15:0] victory_data,
  output logic [15:0] oled_data,
  output logic [1:0]  state,
  output logic [6:0]  wipe_row
);

  localparam int unsigned FW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam int unsigned TW = $clog2(FLASH_COUNT + 1);

  localparam logic [1:0] GAME    = 2'd0;
  localparam logic [1:0] WIPE    = 2'd1;
  localparam logic [1:0] VICTORY = 2'd2;

  localparam logic [12:0] NPIX     = 13'd6144;
  localparam logic [12:0] WIDTH    = 13'd96;
  localparam logic [6:0]  ROWS     = 7'd64;

  logic          in_range;
  logic          invert;
  logic [FW-1:0] frame_cnt;
  logic [TW-1:0] tog_cnt;

  logic [1:0]    state_nx;
  logic [6:0]    wipe_row_nx;
  logic          invert_nx;
  logic [FW-1:0] frame_cnt_nx;
  logic [TW-1:0] tog_cnt_nx;
  logic [7:0]    wipe_sum;
  logic [15:0]   pix_c;

  // Stage 1: linear index to column/row; out-of-range indices park at (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= 7'd0;
      y        <= 6'd0;
      in_range <= 1'b0;
    end else if (pixel_index < NPIX) begin
      x        <= 7'(pixel_index % WIDTH);
      y        <= 6'(pixel_index / WIDTH);
      in_range <= 1'b1;
    end else begin
      x        <= 7'd0;
      y        <= 6'd0;
      in_range <= 1'b0;
    end
  end

  // Transition sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= GAME;
      wipe_row  <= 7'd0;
      invert    <= 1'b0;
      frame_cnt <= '0;
      tog_cnt   <= '0;
    end else begin
      state     <= state_nx;
      wipe_row  <= wipe_row_nx;
      invert    <= invert_nx;
      frame_cnt <= frame_cnt_nx;
      tog_cnt   <= tog_cnt_nx;
    end
  end

  // Next-state: restart wins over frame_begin; otherwise advance only on frame_begin
  always_comb begin
    state_nx     = state;
    wipe_row_nx  = wipe_row;
    invert_nx    = invert;
    frame_cnt_nx = frame_cnt;
    tog_cnt_nx   = tog_cnt;
    wipe_sum     = 8'({1'b0, wipe_row}) + 8'(WIPE_STEP);
    if (restart) begin
      state_nx     = GAME;
      wipe_row_nx  = 7'd0;
      invert_nx    = 1'b0;
      frame_cnt_nx = '0;
      tog_cnt_nx   = '0;
    end else if (frame_begin) begin
      case (state)
        GAME: begin
          if (game_won) begin
            state_nx     = WIPE;
            wipe_row_nx  = 7'd0;
            invert_nx    = 1'b0;
            frame_cnt_nx = '0;
            tog_cnt_nx   = '0;
          end
        end
        WIPE: begin
          if (wipe_sum >= 8'({1'b0, ROWS})) begin
            state_nx     = VICTORY;
            wipe_row_nx  = ROWS;
            invert_nx    = 1'b0;
            frame_cnt_nx = '0;
            tog_cnt_nx   = '0;
          end else begin
            wipe_row_nx  = 7'(wipe_sum);
          end
        end
        VICTORY: begin
          if (tog_cnt < TW'(FLASH_COUNT)) begin
            if (frame_cnt == FW'(FLASH_PERIOD - 1)) begin
              frame_cnt_nx = '0;
              invert_nx    = ~invert;
              tog_cnt_nx   = tog_cnt + 1'b1;
            end else begin
              frame_cnt_nx = frame_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nx    = GAME;
          wipe_row_nx = 7'd0;
        end
      endcase
    end
  end

  // Pixel mix for the current state; renderer inputs already reflect x/y
  always_comb begin
    pix_c = 16'h0000;
    case (state)
      GAME:    pix_c = game_data;
      WIPE:    pix_c = ({1'b0, y} < wipe_row) ? victory_data : game_data;
      VICTORY: pix_c = invert ? ~victory_data : victory_data;
      default: pix_c = 16'h0000;
    endcase
  end

  // Stage 2: registered output pixel, blanked for out-of-range indices
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oled_data <= 16'h0000;
    end else begin
      oled_data <= in_range ? pix_c : 16'h0000;
    end
  end

endmodule

// File: tb/tb_screen_compositor.sv
// Directed self-checking bench for screen_compositor.
module tb_screen_compositor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] pixel_index;
  logic        frame_begin;
  logic        game_won;
  logic        restart;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [15:0] game_data;
  logic [15:0] victory_data;
  logic [15:0] oled_data;
  logic [1:0]  state;
  logic [6:0]  wipe_row;

  logic        gmode;
  logic [15:0] gconst;

  int checks = 0;
  int errors = 0;

  // Game renderer stand-in: either a coordinate-tagged pattern or a constant
  assign game_data = gmode ? {3'b101, x, y} : gconst;

  screen_compositor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pixel_index  (pixel_index),
    .frame_begin  (frame_begin),
    .game_won     (game_won),
    .restart      (restart),
    .x            (x),
    .y            (y),
    .game_data    (game_data),
    .victory_data (victory_data),
    .oled_data    (oled_data),
    .state        (state),
    .wipe_row     (wipe_row)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame_begin pulse followed by an idle cycle so stage 2 sees the new state
  task automatic fb();
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [12:0] pis [5];
  logic [6:0]  exs [5];
  logic [5:0]  eys [5];
  logic [15:0] eds [5];

  initial begin
    pis[0] = 13'd0;    exs[0] = 7'd0;  eys[0] = 6'd0;  eds[0] = 16'hA000;
    pis[1] = 13'd95;   exs[1] = 7'd95; eys[1] = 6'd0;  eds[1] = 16'hB7C0;
    pis[2] = 13'd96;   exs[2] = 7'd0;  eys[2] = 6'd1;  eds[2] = 16'hA001;
    pis[3] = 13'd6143; exs[3] = 7'd95; eys[3] = 6'd63; eds[3] = 16'hB7FF;
    pis[4] = 13'd6144; exs[4] = 7'd0;  eys[4] = 6'd0;  eds[4] = 16'h0000;

    rst_n        = 1'b0;
    pixel_index  = 13'd0;
    frame_begin  = 1'b0;
    game_won     = 1'b0;
    restart      = 1'b0;
    victory_data = 16'hFFFF;
    gmode        = 1'b1;
    gconst       = 16'h0000;

    // Reset values
    #12;
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_oled", 32'(oled_data), 32'h0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_wipe_row", 32'(wipe_row), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Coordinate pipeline and 2-cycle latency, including out-of-range index
    for (int i = 0; i < 5; i++) begin
      pixel_index = pis[i];
      tick();
      chk($sformatf("x[%0d]", i), 32'(x), 32'(exs[i]));
      chk($sformatf("y[%0d]", i), 32'(y), 32'(eys[i]));
      if (i > 0) chk($sformatf("oled[%0d]", i - 1), 32'(oled_data), 32'(eds[i - 1]));
    end
    tick();
    chk("oled[4]", 32'(oled_data), 32'(eds[4]));

    // Enter WIPE
    gmode        = 1'b0;
    gconst       = 16'h001F;
    victory_data = 16'hFFFF;
    pixel_index  = 13'd0;
    game_won     = 1'b1;
    fb();
    chk("wipe_enter_state", 32'(state), 32'd1);
    chk("wipe_enter_row", 32'(wipe_row), 32'd0);
    chk("wipe_row0_pix", 32'(oled_data), 32'h001F);
    for (int i = 0; i < 5; i++) fb();
    chk("wipe_row10", 32'(wipe_row), 32'd10);
    pixel_index = 13'd864;   // y=9
    tick(); tick();
    chk("wipe_y9", 32'(oled_data), 32'hFFFF);
    pixel_index = 13'd960;   // y=10
    tick(); tick();
    chk("wipe_y10", 32'(oled_data), 32'h001F);

    // Finish the wipe with game_won dropped
    game_won = 1'b0;
    for (int i = 0; i < 26; i++) fb();
    chk("wipe31_state", 32'(state), 32'd1);
    chk("wipe31_row", 32'(wipe_row), 32'd62);
    fb();
    chk("wipe32_state", 32'(state), 32'd2);
    chk("wipe32_row", 32'(wipe_row), 32'd64);

    // Victory flash
    victory_data = 16'h07E0;
    pixel_index  = 13'd0;
    tick(); tick();
    chk("vic_frame0", 32'(oled_data), 32'h07E0);
    for (int i = 0; i < 7; i++) fb();
    chk("vic_fb7", 32'(oled_data), 32'h07E0);
    fb();
    chk("vic_fb8", 32'(oled_data), 32'hF81F);
    for (int i = 0; i < 39; i++) fb();
    chk("vic_fb47", 32'(oled_data), 32'hF81F);
    fb();
    chk("vic_fb48", 32'(oled_data), 32'h07E0);
    for (int i = 0; i < 100; i++) fb();
    chk("vic_fb148", 32'(oled_data), 32'h07E0);
    chk("vic_row_hold", 32'(wipe_row), 32'd64);

    // Restart colliding with frame_begin during WIPE at row 20
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_from_vic", 32'(state), 32'd0);
    game_won = 1'b1;
    fb();
    for (int i = 0; i < 10; i++) fb();
    chk("pre_restart_row", 32'(wipe_row), 32'd20);
    victory_data = 16'hAAAA;
    gconst       = 16'h1234;
    pixel_index  = 13'd0;    // y=0 would show victory while wiping
    restart      = 1'b1;
    frame_begin  = 1'b1;
    tick();
    restart      = 1'b0;
    frame_begin  = 1'b0;
    chk("restart_state", 32'(state), 32'd0);
    chk("restart_row", 32'(wipe_row), 32'd0);
    tick();
    chk("restart_pix", 32'(oled_data), 32'h1234);
    game_won = 1'b0;

    // Async reset in the middle of the flash
    game_won     = 1'b1;
    victory_data = 16'h07E0;
    fb();
    game_won = 1'b0;
    for (int i = 0; i < 32; i++) fb();
    for (int i = 0; i < 8; i++) fb();
    chk("preflash_inv_pix", 32'(oled_data), 32'hF81F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_oled", 32'(oled_data), 32'h0);
    chk("async_state", 32'(state), 32'd0);
    chk("async_invert", 32'(dut.invert), 32'd0);
    chk("async_row", 32'(wipe_row), 32'd0);
    #10;
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
